// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the hazard unit and the EX operand muxes in the datapath.
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_EXMEM   = 2'd1;
    localparam logic [1:0] FWD_MEMWB   = 2'd2;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// Single-operand forwarding comparator: picks EX/MEM, MEM/WB or the regfile.
module hazard_fwd_sel
    import hazard_unit_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_we,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_we,
    output logic [1:0]        sel
);

    // A load in EX has no data yet, so only an older MEM writer may supply it.
    always_comb begin
        sel = FWD_REGFILE;
        if (ex_reg_we && !ex_is_load && (ex_rd != '0) && (ex_rd == rs)) begin
            sel = FWD_EXMEM;
        end else if (mem_reg_we && (mem_rd != '0) && (mem_rd == rs)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard control for the 5-stage core: load-use/RAW stalls, redirect and
// jump flushes (registered to line up with synchronous IMEM), forwarding selects.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int REG_AW            = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int FWD_EN            = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [6:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_we,
    input  logic              ex_is_load,
    input  logic              ex_redirect,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_we,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              id_ex_bubble,
    output logic              if_id_flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              busy
);

    if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 7) begin : g_bad_lsc
        $error("hazard_unit: LOAD_STALL_CYCLES must be in 1..7");
    end
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_fc
        $error("hazard_unit: FLUSH_CYCLES must be in 1..7");
    end

    localparam logic [2:0] STALL_LOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    function automatic logic src_hit(
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] rs1,
        input logic              rs1_used,
        input logic [REG_AW-1:0] rs2,
        input logic              rs2_used
    );
        return (rd != '0) && ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
    endfunction

    logic              load_use;
    logic              raw_nofwd;
    logic              stall_haz;
    logic              jump_id;
    logic              ex_hit;
    logic              mem_hit;

    hz_state_t         state;
    hz_state_t         state_nxt;
    logic [2:0]        cnt;
    logic [2:0]        cnt_nxt;
    logic              stall_c;
    logic              bubble_c;
    logic              flush_q;

    logic [REG_AW-1:0] ex_rs1_p1;
    logic [REG_AW-1:0] ex_rs2_p1;
    logic [1:0]        fwd_a_raw;
    logic [1:0]        fwd_b_raw;

    assign ex_hit    = src_hit(ex_rd, id_rs1, id_rs1_used, id_rs2, id_rs2_used);
    assign mem_hit   = src_hit(mem_rd, id_rs1, id_rs1_used, id_rs2, id_rs2_used);
    assign load_use  = id_valid && ex_is_load && ex_reg_we && ex_hit;
    // Without forwarding every in-flight writer the ID instruction reads must drain.
    assign raw_nofwd = (FWD_EN == 0) && id_valid &&
                       ((ex_reg_we && ex_hit) || (mem_reg_we && mem_hit));
    assign stall_haz = load_use || raw_nofwd;
    assign jump_id   = id_valid && ((id_opcode == OPC_JAL) || (id_opcode == OPC_JALR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            cnt     <= '0;
            flush_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            flush_q <= (state_nxt == ST_FLUSH);
        end
    end

    // A redirect overrides whatever sequence is running and restarts the flush.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_c   = 1'b0;
        bubble_c  = 1'b0;
        if (ex_redirect) begin
            bubble_c  = 1'b1;
            state_nxt = ST_FLUSH;
            cnt_nxt   = FLUSH_LOAD;
        end else begin
            case (state)
                ST_STALL: begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    cnt_nxt  = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (cnt == 3'd0) begin
                        state_nxt = ST_RUN;
                    end else begin
                        cnt_nxt = cnt - 3'd1;
                    end
                end
                ST_RUN: begin
                    if (stall_haz) begin
                        stall_c  = 1'b1;
                        bubble_c = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_nxt = ST_STALL;
                            cnt_nxt   = STALL_LOAD;
                        end
                    end else if (jump_id) begin
                        state_nxt = ST_FLUSH;
                        cnt_nxt   = FLUSH_LOAD;
                    end
                end
                default: begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // ID -> EX: source fields of the instruction entering EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs1_p1 <= '0;
            ex_rs2_p1 <= '0;
        end else if (!stall_c) begin
            ex_rs1_p1 <= id_rs1;
            ex_rs2_p1 <= id_rs2;
        end
    end

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs         (ex_rs1_p1),
        .ex_rd      (ex_rd),
        .ex_reg_we  (ex_reg_we),
        .ex_is_load (ex_is_load),
        .mem_rd     (mem_rd),
        .mem_reg_we (mem_reg_we),
        .sel        (fwd_a_raw)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs         (ex_rs2_p1),
        .ex_rd      (ex_rd),
        .ex_reg_we  (ex_reg_we),
        .ex_is_load (ex_is_load),
        .mem_rd     (mem_rd),
        .mem_reg_we (mem_reg_we),
        .sel        (fwd_b_raw)
    );

    assign fwd_a_sel    = (FWD_EN != 0) ? fwd_a_raw : FWD_REGFILE;
    assign fwd_b_sel    = (FWD_EN != 0) ? fwd_b_raw : FWD_REGFILE;

    // Combinational controls are forced low while reset is held.
    assign pc_stall     = rst_n && stall_c;
    assign if_id_stall  = rst_n && stall_c;
    assign id_ex_bubble = rst_n && bubble_c;
    assign if_id_flush  = flush_q;
    assign busy         = (state != ST_RUN);

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (LSC=2/FC=3/fwd on, LSC=1/FC=1/fwd off)
// driven by shared directed and random stimulus, checked against a cycle-window model.
module tb_hazard_unit;

    localparam logic [6:0] OP_ALU  = 7'h33;
    localparam logic [6:0] OP_LOAD = 7'h03;
    localparam logic [6:0] OP_JAL  = 7'h6F;
    localparam logic [6:0] OP_JALR = 7'h67;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2;
    logic       id_rs1_used, id_rs2_used;
    logic [4:0] ex_rd;
    logic       ex_reg_we, ex_is_load, ex_redirect;
    logic [4:0] mem_rd;
    logic       mem_reg_we;

    logic       a_pc_stall, a_if_id_stall, a_bubble, a_flush, a_busy;
    logic [1:0] a_fwd_a, a_fwd_b;
    logic       b_pc_stall, b_if_id_stall, b_bubble, b_flush, b_busy;
    logic [1:0] b_fwd_a, b_fwd_b;
    logic [8:0] a_out, b_out;

    assign a_out = {a_pc_stall, a_if_id_stall, a_bubble, a_flush, a_busy, a_fwd_a, a_fwd_b};
    assign b_out = {b_pc_stall, b_if_id_stall, b_bubble, b_flush, b_busy, b_fwd_a, b_fwd_b};

    int checks;
    int errors;

    int         cyc;
    int         stall_end [2];
    int         flush_s   [2];
    int         flush_e   [2];
    int         m_lsc     [2];
    int         m_fc      [2];
    int         m_fwd     [2];
    logic [4:0] m_rs1     [2];
    logic [4:0] m_rs2     [2];

    hazard_unit #(.REG_AW(5), .LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(3), .FWD_EN(1)) u_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
        .mem_rd(mem_rd), .mem_reg_we(mem_reg_we),
        .pc_stall(a_pc_stall), .if_id_stall(a_if_id_stall), .id_ex_bubble(a_bubble),
        .if_id_flush(a_flush), .fwd_a_sel(a_fwd_a), .fwd_b_sel(a_fwd_b), .busy(a_busy)
    );

    hazard_unit #(.REG_AW(5), .LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .FWD_EN(0)) u_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
        .mem_rd(mem_rd), .mem_reg_we(mem_reg_we),
        .pc_stall(b_pc_stall), .if_id_stall(b_if_id_stall), .id_ex_bubble(b_bubble),
        .if_id_flush(b_flush), .fwd_a_sel(b_fwd_a), .fwd_b_sel(b_fwd_b), .busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        id_valid    = 1'b0;
        id_opcode   = OP_ALU;
        id_rs1      = 5'd0;
        id_rs2      = 5'd0;
        id_rs1_used = 1'b0;
        id_rs2_used = 1'b0;
        ex_rd       = 5'd0;
        ex_reg_we   = 1'b0;
        ex_is_load  = 1'b0;
        ex_redirect = 1'b0;
        mem_rd      = 5'd0;
        mem_reg_we  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_inputs();
        id_valid    = 1'b1;
        id_opcode   = OP_ALU;
        id_rs1      = 5'd5;
        id_rs1_used = 1'b1;
        id_rs2      = 5'd1;
        id_rs2_used = 1'b1;
        ex_rd       = 5'd5;
        ex_reg_we   = 1'b1;
        ex_is_load  = 1'b1;
    endtask

    // Reference model: stall and flush are windows of absolute cycle numbers.
    function automatic logic reads(input logic [4:0] rd);
        return (rd != 5'd0) && ((id_rs1_used && id_rs1 == rd) || (id_rs2_used && id_rs2 == rd));
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] rs);
        if (ex_reg_we && !ex_is_load && ex_rd != 5'd0 && ex_rd == rs) return 2'd1;
        if (mem_reg_we && mem_rd != 5'd0 && mem_rd == rs) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        cyc = 0;
        m_lsc = '{2, 1};
        m_fc  = '{3, 1};
        m_fwd = '{1, 0};
        for (int d = 0; d < 2; d++) begin
            stall_end[d] = -1;
            flush_s[d]   = 1;
            flush_e[d]   = 0;
            m_rs1[d]     = 5'd0;
            m_rs2[d]     = 5'd0;
        end
    endtask

    task automatic model_cycle(input int d, output logic [8:0] e);
        logic in_stall, in_flush, run, haz, jmp, st, bb;
        logic [1:0] fa, fb;
        in_stall = (cyc <= stall_end[d]);
        in_flush = (cyc >= flush_s[d]) && (cyc <= flush_e[d]);
        run      = !in_stall && !in_flush;
        haz      = id_valid && ex_reg_we && ex_is_load && reads(ex_rd);
        if (m_fwd[d] == 0)
            haz = haz || (id_valid && ((ex_reg_we && reads(ex_rd)) || (mem_reg_we && reads(mem_rd))));
        jmp = id_valid && (id_opcode == OP_JAL || id_opcode == OP_JALR);
        st  = 1'b0;
        bb  = 1'b0;
        if (ex_redirect) begin
            bb = 1'b1;
            flush_s[d] = cyc + 1;
            flush_e[d] = cyc + m_fc[d];
            stall_end[d] = -1;
        end else if (in_stall) begin
            st = 1'b1;
            bb = 1'b1;
        end else if (run && haz) begin
            st = 1'b1;
            bb = 1'b1;
            stall_end[d] = cyc + m_lsc[d] - 1;
        end else if (run && jmp) begin
            flush_s[d] = cyc + 1;
            flush_e[d] = cyc + m_fc[d];
        end
        fa = (m_fwd[d] != 0) ? fsel(m_rs1[d]) : 2'd0;
        fb = (m_fwd[d] != 0) ? fsel(m_rs2[d]) : 2'd0;
        e  = {st, st, bb, in_flush, !run, fa, fb};
        if (!st) begin
            m_rs1[d] = id_rs1;
            m_rs2[d] = id_rs2;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a_out !== 9'd0 || b_out !== 9'd0) begin
            errors++;
            $display("FAIL reset_hold a=%b b=%b required 0", a_out, b_out);
        end
        rst_n = 1'b1;
        tick();
        id_valid  = 1'b1;
        id_opcode = OP_JAL;
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (a_out !== 9'b000110000) begin
            errors++;
            $display("FAIL reset_preflush a=%b required 000110000", a_out);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (a_out !== 9'd0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_midflush a=%b required 0", a_out);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (a_out !== 9'd0) begin
                errors++;
                $display("FAIL reset_run k=%0d a=%b required 0", k, a_out);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        load_use_inputs();
        @(negedge clk);
        checks++;
        if (a_out !== 9'b111000000 || b_out !== 9'b111000000) begin
            errors++;
            $display("FAIL lu_T a=%b b=%b required 111000000", a_out, b_out);
        end
        tick();
        ex_rd = 5'd0; ex_reg_we = 1'b0; ex_is_load = 1'b0;
        @(negedge clk);
        checks++;
        if (a_out !== 9'b111010000) begin
            errors++;
            $display("FAIL lu_T1_a a=%b required 111010000", a_out);
        end
        checks++;
        if (b_out !== 9'd0) begin
            errors++;
            $display("FAIL lu_T1_b b=%b required 0", b_out);
        end
        tick();
        @(negedge clk);
        checks++;
        if (a_out !== 9'd0) begin
            errors++;
            $display("FAIL lu_T2_a a=%b required 0", a_out);
        end
        tick();
        load_use_inputs();
        ex_rd  = 5'd0;
        id_rs1 = 5'd0;
        @(negedge clk);
        checks++;
        if (a_out[8:4] !== 5'd0 || b_out[8:4] !== 5'd0) begin
            errors++;
            $display("FAIL lu_x0 a=%b b=%b required no stall", a_out[8:4], b_out[8:4]);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_jump();
        id_valid  = 1'b1;
        id_opcode = OP_JAL;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({a_flush, a_busy, a_bubble} !== {{2{k >= 1 && k <= 3}}, 1'b0}) begin
                errors++;
                $display("FAIL jal_a k=%0d flush,busy,bubble=%b%b%b", k, a_flush, a_busy, a_bubble);
            end
            checks++;
            if ({b_flush, b_busy, b_bubble} !== {{2{k == 1}}, 1'b0}) begin
                errors++;
                $display("FAIL jal_b k=%0d flush,busy,bubble=%b%b%b", k, b_flush, b_busy, b_bubble);
            end
            tick();
            idle();
        end
    endtask

    task automatic test_simultaneous();
        load_use_inputs();
        ex_redirect = 1'b1;
        @(negedge clk);
        checks++;
        if (a_out[8:4] !== 5'b00100 || b_out[8:4] !== 5'b00100) begin
            errors++;
            $display("FAIL redir_lu a=%b b=%b required 00100", a_out[8:4], b_out[8:4]);
        end
        tick();
        idle();
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({a_out[8:4], b_out[8:4]} !== {3'b000, {2{k <= 3}}, 3'b000, {2{k == 1}}}) begin
                errors++;
                $display("FAIL redir_flush k=%0d a=%b b=%b", k, a_out[8:4], b_out[8:4]);
            end
            tick();
        end
        load_use_inputs();
        @(negedge clk);
        checks++;
        if (a_out[8:4] !== 5'b11100) begin
            errors++;
            $display("FAIL stall_enter a=%b required 11100", a_out[8:4]);
        end
        tick();
        ex_is_load  = 1'b0;
        ex_reg_we   = 1'b0;
        ex_redirect = 1'b1;
        @(negedge clk);
        checks++;
        if (a_out[8:4] !== 5'b00101) begin
            errors++;
            $display("FAIL redir_in_stall a=%b required 00101", a_out[8:4]);
        end
        checks++;
        if (b_out[8:4] !== 5'b00100) begin
            errors++;
            $display("FAIL redir_run_b b=%b required 00100", b_out[8:4]);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (a_out[8:4] !== 5'b00011 || b_out[8:4] !== 5'b00011) begin
            errors++;
            $display("FAIL redir_follow a=%b b=%b required 00011", a_out[8:4], b_out[8:4]);
        end
        repeat (4) tick();
    endtask

    task automatic test_forwarding();
        id_valid = 1'b1; id_opcode = OP_ALU;
        id_rs1 = 5'd3; id_rs1_used = 1'b1;
        id_rs2 = 5'd7; id_rs2_used = 1'b1;
        tick();
        ex_rd = 5'd3; ex_reg_we = 1'b1;
        mem_rd = 5'd3; mem_reg_we = 1'b1;
        @(negedge clk);
        checks++;
        if (a_fwd_a !== 2'd1 || a_pc_stall !== 1'b0) begin
            errors++;
            $display("FAIL fwd_ex_beats_mem sel=%0d stall=%b required 1/0", a_fwd_a, a_pc_stall);
        end
        checks++;
        if (b_fwd_a !== 2'd0 || b_pc_stall !== 1'b1) begin
            errors++;
            $display("FAIL nofwd_stall sel=%0d stall=%b required 0/1", b_fwd_a, b_pc_stall);
        end
        tick();
        id_valid = 1'b0; id_rs2 = 5'd3;
        ex_rd = 5'd4;
        @(negedge clk);
        checks++;
        if (a_fwd_a !== 2'd2 || a_fwd_b !== 2'd0) begin
            errors++;
            $display("FAIL fwd_mem a=%0d b=%0d required 2/0", a_fwd_a, a_fwd_b);
        end
        tick();
        ex_rd = 5'd3; ex_is_load = 1'b1; id_rs1 = 5'd0;
        @(negedge clk);
        checks++;
        if (a_fwd_a !== 2'd2 || a_fwd_b !== 2'd2) begin
            errors++;
            $display("FAIL fwd_load_ex a=%0d b=%0d required 2/2", a_fwd_a, a_fwd_b);
        end
        tick();
        ex_is_load = 1'b0; mem_reg_we = 1'b0;
        @(negedge clk);
        checks++;
        if (a_fwd_a !== 2'd0 || a_fwd_b !== 2'd1) begin
            errors++;
            $display("FAIL fwd_rs2_ex a=%0d b=%0d required 0/1", a_fwd_a, a_fwd_b);
        end
        tick();
        ex_rd = 5'd0; mem_rd = 5'd0; mem_reg_we = 1'b1;
        @(negedge clk);
        checks++;
        if (a_fwd_a !== 2'd0) begin
            errors++;
            $display("FAIL fwd_x0 sel=%0d required 0", a_fwd_a);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [8:0] ea, eb;
        int r;
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            id_valid    = 1'($urandom_range(0, 3) != 0);
            r           = int'($urandom_range(0, 9));
            id_opcode   = (r == 0) ? OP_JAL : (r == 1) ? OP_JALR : (r < 4) ? OP_LOAD : OP_ALU;
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_rs1_used = 1'($urandom_range(0, 1));
            id_rs2_used = 1'($urandom_range(0, 1));
            ex_rd       = 5'($urandom_range(0, 3));
            ex_reg_we   = 1'($urandom_range(0, 1));
            ex_is_load  = 1'($urandom_range(0, 1));
            ex_redirect = 1'($urandom_range(0, 11) == 0);
            mem_rd      = 5'($urandom_range(0, 3));
            mem_reg_we  = 1'($urandom_range(0, 1));
            @(negedge clk);
            model_cycle(0, ea);
            model_cycle(1, eb);
            checks++;
            if (a_out !== ea) begin
                errors++;
                $display("FAIL rand_a cyc=%0d got=%b required=%b", cyc, a_out, ea);
            end
            checks++;
            if (b_out !== eb) begin
                errors++;
                $display("FAIL rand_b cyc=%0d got=%b required=%b", cyc, b_out, eb);
            end
            cyc++;
            tick();
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_jump();
        test_simultaneous();
        test_forwarding();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
